dense_layer_stream: RTL and testbench



---
 rtl/dense_pkg.sv | 28 ++
 rtl/dense_mac_lane.sv | 82 ++++++++
 rtl/dense_layer_stream.sv | 95 +++++++++
 tb/tb_dense_layer_stream.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared helpers for the streaming dense layer: accumulator sizing and
// signed saturation.
package dense_pkg;

    function automatic int unsigned acc_width(input int unsigned bw_in,
                                              input int unsigned bw_w,
                                              input int unsigned input_size,
                                              input int unsigned num_cyc);
        return bw_in + 1 + bw_w + $clog2(input_size) + $clog2(num_cyc) + 1;
    endfunction

    // Clamp a wide signed value into the signed range of a bw-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                                 input int unsigned bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One neuron of the streaming dense layer: per-beat dot product, running
// accumulator, and bias/shift/ReLU/saturate requantisation on the final beat.
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int unsigned INPUT_SIZE        = 4,
    parameter int unsigned NUM_CYC           = 512,
    parameter int unsigned BW_IN             = 16,
    parameter int unsigned BW_W              = 2,
    parameter int unsigned BW_B              = 16,
    parameter int unsigned BW_OUT            = 16,
    parameter int unsigned R_SHIFT           = 0,
    parameter int unsigned USE_UNSIGNED_DATA = 0,
    parameter int unsigned USE_RELU          = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               acc_en_i,
    input  logic                               first_i,
    input  logic                               last_i,
    input  logic [INPUT_SIZE*BW_W-1:0]         w_i,
    input  logic [INPUT_SIZE-1:0][BW_IN-1:0]   data_i,
    input  logic [BW_B-1:0]                    bias_i,
    output logic [BW_OUT-1:0]                  res_o
);

    localparam int unsigned BwAcc = acc_width(BW_IN, BW_W, INPUT_SIZE, NUM_CYC);

    logic signed [63:0]      p_wide;
    logic signed [BwAcc-1:0] acc_q;
    logic signed [BwAcc-1:0] acc_base;
    logic signed [BwAcc-1:0] acc_sum;
    logic signed [63:0]      s;
    logic signed [63:0]      s_sat;
    logic [BW_OUT-1:0]       res_d;
    logic [BW_OUT-1:0]       res_q;

    always_comb begin
        logic signed [63:0] smp;
        logic signed [63:0] wt;
        p_wide = '0;
        smp    = '0;
        wt     = '0;
        for (int k = 0; k < int'(INPUT_SIZE); k++) begin
            smp = (USE_UNSIGNED_DATA != 0) ? $signed(64'(data_i[k]))
                                           : 64'(signed'(data_i[k]));
            wt  = 64'(signed'(w_i[k*BW_W +: BW_W]));
            p_wide = p_wide + smp * wt;
        end
    end

    // Beat 0 restarts the sum, which also covers NUM_CYC == 1.
    assign acc_base = first_i ? '0 : acc_q;
    assign acc_sum  = acc_base + BwAcc'(p_wide);

    always_comb begin
        s = 64'(acc_sum) + 64'(signed'(bias_i));
        s = s >>> R_SHIFT;
        if ((USE_RELU != 0) && (s < 0)) begin
            s = '0;
        end
        s_sat = sat_s(s, BW_OUT);
        res_d = s_sat[BW_OUT-1:0];
    end

    always_ff @(posedge clk) begin
        if (acc_en_i) begin
            acc_q <= acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (acc_en_i && last_i) begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/dense_layer_stream.sv
// Streaming fully-connected layer: beat counter, valid/ready handshake and
// output valid register around OUTPUT_SIZE parallel neuron lanes.
module dense_layer_stream
    import dense_pkg::*;
#(
    parameter int unsigned INPUT_SIZE        = 4,
    parameter int unsigned NUM_CYC           = 512,
    parameter int unsigned OUTPUT_SIZE       = 128,
    parameter int unsigned BW_IN             = 16,
    parameter int unsigned BW_W              = 2,
    parameter int unsigned BW_B              = 16,
    parameter int unsigned BW_OUT            = 16,
    parameter int unsigned R_SHIFT           = 0,
    parameter int unsigned USE_UNSIGNED_DATA = 0,
    parameter int unsigned USE_RELU          = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    vld_in,
    output logic                                    rdy_in,
    input  logic [OUTPUT_SIZE-1:0][INPUT_SIZE*BW_W-1:0] w_vec,
    input  logic [INPUT_SIZE-1:0][BW_IN-1:0]        data_in,
    input  logic [OUTPUT_SIZE-1:0][BW_B-1:0]        bias,
    output logic                                    vld_out,
    input  logic                                    rdy_out,
    output logic [OUTPUT_SIZE-1:0][BW_OUT-1:0]      data_out
);

    localparam int unsigned CntW = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_CYC - 1);

    logic [CntW-1:0] cntr_q;
    logic [CntW-1:0] cntr_d;
    logic            vld_q;
    logic            vld_d;
    logic            first;
    logic            last;
    logic            accept;

    assign first  = (cntr_q == '0);
    assign last   = (cntr_q == LastCnt);
    // Only the final beat waits on a pending, unconsumed result.
    assign rdy_in = !(last && vld_q && !rdy_out);
    assign accept = vld_in && rdy_in;

    always_comb begin
        cntr_d = cntr_q;
        if (accept) begin
            cntr_d = last ? '0 : cntr_q + 1'b1;
        end
        vld_d = vld_q;
        if (accept && last) begin
            vld_d = 1'b1;
        end else if (rdy_out) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cntr_q <= cntr_d;
            vld_q  <= vld_d;
        end
    end

    assign vld_out = vld_q;

    for (genvar i = 0; i < int'(OUTPUT_SIZE); i++) begin : g_lane
        dense_mac_lane #(
            .INPUT_SIZE       (INPUT_SIZE),
            .NUM_CYC          (NUM_CYC),
            .BW_IN            (BW_IN),
            .BW_W             (BW_W),
            .BW_B             (BW_B),
            .BW_OUT           (BW_OUT),
            .R_SHIFT          (R_SHIFT),
            .USE_UNSIGNED_DATA(USE_UNSIGNED_DATA),
            .USE_RELU         (USE_RELU)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .acc_en_i(accept),
            .first_i (first),
            .last_i  (last),
            .w_i     (w_vec[i]),
            .data_i  (data_in),
            .bias_i  (bias[i]),
            .res_o   (data_out[i])
        );
    end

endmodule

// File: tb/tb_dense_layer_stream.sv
// Directed bench: three NUM_CYC=2 variants (ReLU, plain, shift-by-2) on shared
// stimulus, plus NUM_CYC=8 and NUM_CYC=512 instances for saturation and reset.
module tb_dense_layer_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Shared stimulus for the NUM_CYC=2 instances (two neurons each).
    logic             vld_a;
    logic             rdy_out_a;
    logic [3:0][15:0] data_a;
    logic [1:0][7:0]  w_a;
    logic [1:0][15:0] bias_a;
    logic             rdy_in_a, rdy_in_b, rdy_in_c;
    logic             vo_a, vo_b, vo_c;
    logic [1:0][15:0] do_a, do_b, do_c;

    // Shared stimulus for the NUM_CYC=8 and NUM_CYC=512 instances.
    logic             vld_d;
    logic [3:0][15:0] data_d;
    logic [0:0][7:0]  w_d;
    logic [0:0][15:0] bias_d;
    logic             rdy_in_d, rdy_in_e;
    logic             vo_d, vo_e;
    logic [0:0][15:0] do_d, do_e;

    dense_layer_stream #(.INPUT_SIZE(4), .NUM_CYC(2), .OUTPUT_SIZE(2), .R_SHIFT(0), .USE_RELU(1))
    dut_a (.clk(clk), .rst(rst), .vld_in(vld_a), .rdy_in(rdy_in_a), .w_vec(w_a), .data_in(data_a),
           .bias(bias_a), .vld_out(vo_a), .rdy_out(rdy_out_a), .data_out(do_a));

    dense_layer_stream #(.INPUT_SIZE(4), .NUM_CYC(2), .OUTPUT_SIZE(2), .R_SHIFT(0), .USE_RELU(0))
    dut_b (.clk(clk), .rst(rst), .vld_in(vld_a), .rdy_in(rdy_in_b), .w_vec(w_a), .data_in(data_a),
           .bias(bias_a), .vld_out(vo_b), .rdy_out(rdy_out_a), .data_out(do_b));

    dense_layer_stream #(.INPUT_SIZE(4), .NUM_CYC(2), .OUTPUT_SIZE(2), .R_SHIFT(2), .USE_RELU(0))
    dut_c (.clk(clk), .rst(rst), .vld_in(vld_a), .rdy_in(rdy_in_c), .w_vec(w_a), .data_in(data_a),
           .bias(bias_a), .vld_out(vo_c), .rdy_out(rdy_out_a), .data_out(do_c));

    dense_layer_stream #(.INPUT_SIZE(4), .NUM_CYC(8), .OUTPUT_SIZE(1), .R_SHIFT(0), .USE_RELU(0))
    dut_d (.clk(clk), .rst(rst), .vld_in(vld_d), .rdy_in(rdy_in_d), .w_vec(w_d), .data_in(data_d),
           .bias(bias_d), .vld_out(vo_d), .rdy_out(1'b1), .data_out(do_d));

    dense_layer_stream #(.INPUT_SIZE(4), .NUM_CYC(512), .OUTPUT_SIZE(1), .R_SHIFT(0), .USE_RELU(0))
    dut_e (.clk(clk), .rst(rst), .vld_in(vld_d), .rdy_in(rdy_in_e), .w_vec(w_d), .data_in(data_d),
           .bias(bias_d), .vld_out(vo_e), .rdy_out(1'b1), .data_out(do_e));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        vld_a     = 1'b0;
        rdy_out_a = 1'b1;
        data_a    = '0;
        w_a       = '0;
        bias_a    = '0;
        vld_d     = 1'b0;
        data_d    = '0;
        w_d       = '0;
        bias_d    = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_vld_a", 16'(vo_a), 16'd0);
        chk("rst_do_a0", do_a[0], 16'd0);
        chk("rst_rdy_a", 16'(rdy_in_a), 16'd1);
        chk("rst_rdy_d", 16'(rdy_in_d), 16'd1);
        chk("rst_rdy_e", 16'(rdy_in_e), 16'd1);
        rst = 1'b0;

        // Vector 1: n0 weights +1 -> 20+5=25; n1 weights -1 -> -20+5=-15
        data_a = {16'd4, 16'd3, 16'd2, 16'd1};
        w_a    = {8'hFF, 8'h55};
        bias_a = {16'd5, 16'd5};
        vld_a  = 1'b1;
        tick();
        chk("v1_no_early_vld", 16'(vo_a), 16'd0);
        tick();
        chk("v1_vld_a", 16'(vo_a), 16'd1);
        chk("v1_a_n0", do_a[0], 16'd25);
        chk("v1_a_n1_relu", do_a[1], 16'd0);
        chk("v1_b_n1", do_b[1], -16'sd15);
        chk("v1_c_n0_shift", do_c[0], 16'd6);
        chk("v1_c_n1_floor", do_c[1], -16'sd4);

        // Vector 2 back-to-back: n0 20-25=-5, n1 -20-25=-45
        bias_a = {-16'sd25, -16'sd25};
        tick();
        chk("v2_vld_drained", 16'(vo_a), 16'd0);
        tick();
        chk("v2_vld_b", 16'(vo_b), 16'd1);
        chk("v2_a_n0_relu", do_a[0], 16'd0);
        chk("v2_b_n0", do_b[0], -16'sd5);
        chk("v2_b_n1", do_b[1], -16'sd45);
        chk("v2_c_n0_floor", do_c[0], -16'sd2);
        chk("v2_c_n1_floor", do_c[1], -16'sd12);

        // Vector 3 (result 25), then back-pressure while vector 4 streams
        bias_a = {16'd5, 16'd5};
        tick();
        tick();
        chk("v3_a_n0", do_a[0], 16'd25);
        rdy_out_a = 1'b0;
        data_a    = {16'd4, 16'd4, 16'd4, 16'd4};
        bias_a    = {16'd0, 16'd0};
        chk("bp_rdy_beat0", 16'(rdy_in_a), 16'd1);
        tick();
        chk("bp_rdy_final_stall", 16'(rdy_in_a), 16'd0);
        chk("bp_rdy_b_match", 16'(rdy_in_b), 16'd0);
        tick();
        tick();
        chk("bp_vld_hold", 16'(vo_a), 16'd1);
        chk("bp_data_stable", do_a[0], 16'd25);
        chk("bp_rdy_still_low", 16'(rdy_in_a), 16'd0);
        rdy_out_a = 1'b1;
        #1;
        chk("bp_rdy_release", 16'(rdy_in_a), 16'd1);
        tick();
        chk("v4_vld_no_bubble", 16'(vo_a), 16'd1);
        chk("v4_a_n0", do_a[0], 16'd32);
        chk("v4_b_n1", do_b[1], -16'sd32);
        vld_a = 1'b0;
        tick();
        chk("v4_vld_drained", 16'(vo_a), 16'd0);

        // Saturation: 512 beats of 4x32767 with +1 weights, then -1 weights
        data_d = {4{16'd32767}};
        w_d    = {8'h55};
        bias_d = {16'd0};
        vld_d  = 1'b1;
        repeat (511) tick();
        chk("sat_e_no_early_vld", 16'(vo_e), 16'd0);
        tick();
        chk("sat_e_vld", 16'(vo_e), 16'd1);
        chk("sat_e_pos", do_e[0], 16'h7FFF);
        chk("sat_d_pos", do_d[0], 16'h7FFF);
        w_d = {8'hFF};
        repeat (512) tick();
        chk("sat_e_neg", do_e[0], 16'h8000);
        chk("sat_d_neg", do_d[0], 16'h8000);
        vld_d = 1'b0;
        tick();

        // Reset mid-vector after 3 of 8 beats, then one clean vector
        data_d = {4{16'd10}};
        w_d    = {8'h55};
        vld_d  = 1'b1;
        repeat (3) tick();
        vld_d = 1'b0;
        rst   = 1'b1;
        tick();
        chk("mid_rst_vld_d", 16'(vo_d), 16'd0);
        chk("mid_rst_do_d", do_d[0], 16'd0);
        rst    = 1'b0;
        data_d = {16'd4, 16'd3, 16'd2, 16'd1};
        bias_d = {16'd7};
        vld_d  = 1'b1;
        repeat (7) tick();
        chk("post_rst_no_early", 16'(vo_d), 16'd0);
        tick();
        chk("post_rst_vld", 16'(vo_d), 16'd1);
        chk("post_rst_sum", do_d[0], 16'd87);
        vld_d = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
